neuron_mac_seq: RTL



---
 rtl/neuron_mac_seq.sv | 74 +++++++
 1 files changed

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential multiply-accumulate neuron with step or saturating-linear activation
module neuron_mac_seq #(
    parameter int N_IN = 4,
    parameter int DW   = 4,
    parameter int AW   = 2*DW + $clog2(N_IN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [N_IN*DW-1:0] in_vec,
    input  logic [N_IN*DW-1:0] w_vec,
    input  logic [AW-1:0]      T,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      sum,
    output logic [DW-1:0]      outf
);
    localparam int IW = $clog2(N_IN);
    typedef enum logic [1:0] {IDLE, ACC, CMP} state_t;
    state_t state, state_nxt;
    logic [N_IN*DW-1:0] in_q, w_q;
    logic [AW-1:0]      t_q, acc, acc_nxt, diff;
    logic               mode_q, accept, last, fire;
    logic [IW-1:0]      idx;
    logic [DW-1:0]      in_x, w_x, outf_nxt;
    logic [2*DW-1:0]    prod;
    // The result is registered on the final ACC edge so it is already valid
    // during CMP, which is the done cycle and may also accept the next start.
    always_comb begin
        in_x      = in_q[idx*DW +: DW];
        w_x       = w_q[idx*DW +: DW];
        prod      = {{DW{1'b0}}, in_x} * {{DW{1'b0}}, w_x};
        acc_nxt   = acc + AW'(prod);
        last      = idx == IW'(N_IN - 1);
        fire      = acc_nxt >= t_q;
        diff      = acc_nxt - t_q;
        outf_nxt  = !fire ? '0 : !mode_q ? '1 : (|diff[AW-1:DW]) ? '1 : diff[DW-1:0];
        accept    = start && (state == IDLE || state == CMP);
        state_nxt = accept ? ACC : (state == ACC && last) ? CMP : (state == CMP) ? IDLE : state;
        busy      = state != IDLE;
        done      = state == CMP;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= '0;
            sum    <= '0;
            outf   <= '0;
            in_q   <= '0;
            w_q    <= '0;
            t_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                in_q   <= in_vec;
                w_q    <= w_vec;
                t_q    <= T;
                mode_q <= mode;
                acc    <= '0;
                idx    <= '0;
            end else if (state == ACC) begin
                acc <= acc_nxt;
                idx <= idx + 1'b1;
                if (last) begin
                    sum  <= acc_nxt;
                    outf <= outf_nxt;
                end
            end
        end
    end
endmodule
